// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : Load/store unit master. Turns one CPU load/store request into
//               SRAM word accesses (read-modify-write for sub-word stores).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        write_enable,
    output logic [31:0] Address,
    output logic [31:0] write_data,
    input  logic        HREADYOUT,
    input  logic [31:0] read_data
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic [7:0]  r_wait_cnt;
    logic        r_we;
    logic [31:0] r_address;
    logic [31:0] r_write_data;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_illegal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;
    logic        w_expired;

    assign req_ready    = (r_state == c_IDLE) && !HRESET;
    assign resp_valid   = (r_state == c_RESP);
    assign resp_rdata   = r_rdata;
    assign resp_err     = r_err;
    assign write_enable = r_we;
    assign Address      = r_address;
    assign write_data   = r_write_data;

    assign w_illegal = (req_size == 2'b11)
                    || ((req_size == c_SZ_HALF) && req_addr[0])
                    || ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00));

    assign w_expired = (r_wait_cnt == c_WAIT_LAST);

    // Little-endian lane selection from the SRAM word
    always_comb begin
        w_byte = read_data[7:0];
        case (r_lane)
            2'd0:    w_byte = read_data[7:0];
            2'd1:    w_byte = read_data[15:8];
            2'd2:    w_byte = read_data[23:16];
            default: w_byte = read_data[31:24];
        endcase
        w_half = r_lane[1] ? read_data[31:16] : read_data[15:0];

        w_load_data = read_data;
        case (r_size)
            c_SZ_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default:   w_load_data = read_data;
        endcase
    end

    // Sub-word store: overwrite only the addressed lane(s) of the read word
    always_comb begin
        w_merged = read_data;
        if (r_size == c_SZ_BYTE) begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata;
        end else begin
            w_merged[15:0] = r_wdata;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state      <= c_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata      <= 16'h0;
            r_wait_cnt   <= 8'h0;
            r_we         <= 1'b0;
            r_address    <= 32'h0;
            r_write_data <= 32'h0;
            r_rdata      <= 32'h0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_signed   <= req_signed;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata[15:0];
                        r_wait_cnt <= 8'h0;
                        r_rdata    <= 32'h0;
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_state <= c_RESP;
                        end else begin
                            r_err     <= 1'b0;
                            r_address <= {req_addr[31:2], 2'b00};
                            if (req_write && (req_size == c_SZ_WORD)) begin
                                r_we         <= 1'b1;
                                r_write_data <= req_wdata;
                                r_state      <= c_WR;
                            end else begin
                                r_we    <= 1'b0;
                                r_state <= c_RD;
                            end
                        end
                    end
                end
                c_RD: begin
                    if (HREADYOUT) begin
                        r_wait_cnt <= 8'h0;
                        if (r_write) begin
                            r_write_data <= w_merged;
                            r_we         <= 1'b1;
                            r_state      <= c_WR;
                        end else begin
                            r_rdata <= w_load_data;
                            r_state <= c_RESP;
                        end
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= c_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                c_WR: begin
                    if (HREADYOUT) begin
                        r_we       <= 1'b0;
                        r_wait_cnt <= 8'h0;
                        r_state    <= c_RESP;
                    end else if (w_expired) begin
                        r_we    <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= c_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                c_RESP: begin
                    if (resp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_master
// Description : Directed self-checking bench for lsu_mem_master with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        write_enable;
    logic [31:0] Address;
    logic [31:0] write_data;
    logic        HREADYOUT = 1'b1;
    logic [31:0] read_data;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cycles = 0;
    int wr_count  = 0;
    logic [31:0] first_addr;
    logic        first_we;

    logic [31:0] mem [0:63];

    lsu_mem_master #(.TIMEOUT(16)) u_dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .write_enable(write_enable),
        .Address     (Address),
        .write_data  (write_data),
        .HREADYOUT   (HREADYOUT),
        .read_data   (read_data)
    );

    always #5 HCLK = ~HCLK;

    assign read_data = mem[Address[7:2]];

    always @(posedge HCLK) begin
        if (write_enable) we_cycles <= we_cycles + 1;
        if (write_enable && HREADYOUT) begin
            mem[Address[7:2]] <= write_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // nwait < 0 holds HREADYOUT low for the whole transfer
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input int nwait,
                          output logic [31:0] rdata, output logic err, output int cycles);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge HCLK); #1; guard++;
        end
        check("req_ready_before", {31'b0, req_ready}, 32'h1);
        HREADYOUT  = (nwait == 0);
        req_write  = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge HCLK); #1;
        req_valid  = 1'b0;
        req_write  = $urandom_range(0, 1);
        req_size   = 2'($urandom_range(0, 3));
        req_signed = $urandom_range(0, 1);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        first_addr = Address;
        first_we   = write_enable;
        cycles = 1;
        while (!resp_valid && cycles < 100) begin
            if (cycles - 1 == nwait) HREADYOUT = 1'b1;
            @(posedge HCLK); #1;
            cycles++;
        end
        check("resp_within_bound", {31'b0, resp_valid}, 32'h1);
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge HCLK); #1;
        check("resp_hold_valid", {31'b0, resp_valid}, 32'h1);
        check("resp_hold_data", resp_rdata, rdata);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_size   = 2'b10;
        req_addr   = 32'h0;
        @(posedge HCLK); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("no_accept_on_resp_exit", {31'b0, req_ready}, 32'h1);
        HREADYOUT = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        int          we_before;
        int          wr_before;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_write_enable", {31'b0, write_enable}, 32'h0);
        check("rst_address", Address, 32'h0);
        check("rst_write_data", write_data, 32'h0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'h0);
        HRESET = 1'b0;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);

        mem[4] = 32'hDEADBEEF;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er, cyc);
        check("lw_addr", first_addr, 32'h10);
        check("lw_we", {31'b0, first_we}, 32'h0);
        check("lw_cycles", cyc, 2);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", {31'b0, er}, 32'h0);

        mem[4] = 32'h11223344;
        wr_before = wr_count;
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA, 0, rd, er, cyc);
        check("sb_cycles", cyc, 3);
        check("sb_mem", mem[4], 32'hAA223344);
        check("sb_wrcount", wr_count - wr_before, 1);
        check("sb_err", {31'b0, er}, 32'h0);
        check("sb_rdata", rd, 32'h0);

        mem[8] = 32'h8001FFFF;
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, rd, er, cyc);
        check("lh_signed", rd, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 0, rd, er, cyc);
        check("lh_unsigned", rd, 32'h00008001);
        do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 0, rd, er, cyc);
        check("lh_signed_low", rd, 32'hFFFFFFFF);
        do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 0, rd, er, cyc);
        check("lb_signed_lane3", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 0, rd, er, cyc);
        check("lb_signed_lane2", rd, 32'h00000001);
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0, rd, er, cyc);
        check("lb_unsigned_lane1", rd, 32'h000000FF);

        we_before = we_cycles;
        do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0, rd, er, cyc);
        check("misalign_w_err", {31'b0, er}, 32'h1);
        check("misalign_w_rdata", rd, 32'h0);
        check("misalign_w_cycles", cyc, 1);
        check("misalign_w_no_we", we_cycles - we_before, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, rd, er, cyc);
        check("illegal_size_err", {31'b0, er}, 32'h1);
        wr_before = wr_count;
        do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234, 0, rd, er, cyc);
        check("misalign_h_err", {31'b0, er}, 32'h1);
        check("misalign_h_no_write", wr_count - wr_before, 0);
        check("misalign_h_mem", mem[8], 32'h8001FFFF);

        do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, 0, rd, er, cyc);
        check("sw_cycles", cyc, 2);
        check("sw_mem", mem[12], 32'h12345678);
        do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000BEEF, 0, rd, er, cyc);
        check("sh_cycles", cyc, 3);
        check("sh_mem", mem[12], 32'hBEEF5678);

        mem[4] = 32'hCAFEF00D;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, rd, er, cyc);
        check("wait3_cycles", cyc, 5);
        check("wait3_rdata", rd, 32'hCAFEF00D);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 15, rd, er, cyc);
        check("wait15_cycles", cyc, 17);
        check("wait15_err", {31'b0, er}, 32'h0);
        check("wait15_rdata", rd, 32'hCAFEF00D);

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, -1, rd, er, cyc);
        check("tmo_rd_cycles", cyc, 17);
        check("tmo_rd_err", {31'b0, er}, 32'h1);
        check("tmo_rd_rdata", rd, 32'h0);

        wr_before = wr_count;
        do_req(1'b1, 2'b10, 1'b0, 32'h34, 32'h55AA55AA, -1, rd, er, cyc);
        check("tmo_wr_cycles", cyc, 17);
        check("tmo_wr_err", {31'b0, er}, 32'h1);
        check("tmo_wr_no_write", wr_count - wr_before, 0);
        check("tmo_wr_we_low", {31'b0, write_enable}, 32'h0);

        // Reset in the middle of a stalled word store
        HREADYOUT = 1'b0;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h40;
        req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
        @(posedge HCLK); #1;
        req_valid = 1'b0;
        check("midwr_we_high", {31'b0, write_enable}, 32'h1);
        #2 HRESET = 1'b1;
        #1;
        check("midwr_we_async_low", {31'b0, write_enable}, 32'h0);
        check("midwr_addr_cleared", Address, 32'h0);
        check("midwr_resp_valid", {31'b0, resp_valid}, 32'h0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        #1;
        check("midwr_req_ready", {31'b0, req_ready}, 32'h1);
        HREADYOUT = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        check("midwr_no_resp", {31'b0, resp_valid}, 32'h0);
        check("midwr_mem", mem[16], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max cycles per SRAM access waiting on HREADYOUT before abort (legal range 2..255).
REQ-002 SHALL have port: HCLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: HRESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  CPU load/store request present.
REQ-005 SHALL have port: req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port: req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port: req_addr  input  32  byte address.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port: resp_valid / resp_ready  output / input  1 / 1  response handshake.
REQ-012 SHALL have port: resp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port: resp_err  output  1  misaligned, illegal size or timeout.
REQ-014 SHALL have port: write_enable  output  1  SRAM write strobe; low = read access.
REQ-015 SHALL have port: Address  output  32  SRAM word address, always {addr[31:2],2'b00}.
REQ-016 SHALL have port: write_data  output  32  full word written to SRAM.
REQ-017 SHALL have port: HREADYOUT  input  1  SRAM access completes on a rising edge where high.
REQ-018 SHALL have port: read_data  input  32  SRAM read word, valid when HREADYOUT high.

Function
REQ-019 SHALL implement FSM states IDLE, RD, WR, RESP.
REQ-020 SHALL accept a request on an edge with req_valid & req_ready, latching write, size, signed, addr, wdata.
REQ-021 SHALL, on acceptance, go to RESP with resp_err=1 and no SRAM access if size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
REQ-022 SHALL, for legal loads and sub-word stores, go IDLE->RD; for word stores go IDLE->WR directly.
REQ-023 SHALL hold Address, write_enable and write_data stable in RD/WR until the completing edge; write_enable=1 only in WR.
REQ-024 SHALL complete RD/WR on the first rising edge with HREADYOUT=1; zero-wait SRAM gives one cycle per state.
REQ-025 SHALL, at RD completion for loads, extract little-endian lane addr[1:0] (byte) or addr[1] (half), extend per req_signed, register into resp_rdata, go RESP.
REQ-026 SHALL, at RD completion for sub-word stores, merge req_wdata into the addressed lane(s) of read_data, keep other bytes unchanged, drive the merged word on write_data, go WR.
REQ-027 SHALL, at WR completion, go RESP with resp_err=0, resp_rdata=0.
REQ-028 SHALL count cycles in RD/WR with HREADYOUT=0, clearing on state entry; on the edge where count reaches TIMEOUT-1 with HREADYOUT=0, abort to RESP with resp_err=1, write_enable low next cycle, no further SRAM access.
REQ-029 SHALL hold resp_valid=1 and resp_rdata/resp_err stable in RESP until an edge with resp_ready=1, then return to IDLE; no new request accepted in the same edge.
REQ-030 SHALL ignore req_* changes after acceptance.

Reset
REQ-031 SHALL on HRESET=1, immediately and asynchronously: state IDLE, write_enable=0, Address=0, write_data=0, resp_valid=0, resp_rdata=0, resp_err=0, timeout count=0; req_ready=1 once HRESET=0.
REQ-032 SHALL abandon any in-flight access on reset mid-operation, with no response issued for it.

Verification
REQ-033 Zero-wait SRAM, load word addr 0x10, memory 0xDEADBEEF -> Address=0x10, write_enable=0, resp_valid after 2 edges, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-034 Store byte 0xAA to addr 0x13, memory 0x11223344 -> RD then WR, write_data=0xAA223344 with write_enable=1, resp_err=0.
REQ-035 Signed half load addr 0x22, memory 0x8001FFFF -> resp_rdata=0xFFFF8001; unsigned -> 0x00008001.
REQ-036 Word load addr 0x02 -> no SRAM access (write_enable stays 0), resp_err=1, resp_rdata=0.
REQ-037 HREADYOUT held 0, TIMEOUT=16 -> abort after 16 cycles in RD, resp_err=1; HRESET pulsed mid-WR -> write_enable=0 same cycle, req_ready=1 after release.
